// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter in front of the single Memory32 port.
// Round-robin or fixed priority, lock for atomic bursts, steered read return.
module mem_port_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_valid,
  input  logic          m0_write,
  input  logic [3:0]    m0_wmask,
  input  logic [31:0]   m0_wdata,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_lock,
  output logic          m0_ready,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  input  logic          m1_write,
  input  logic [3:0]    m1_wmask,
  input  logic [31:0]   m1_wdata,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_lock,
  output logic          m1_ready,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          mem_valid,
  output logic          mem_write,
  output logic [3:0]    mem_wmask,
  output logic [31:0]   mem_wdata,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } lock_state_t;

  lock_state_t state;
  lock_state_t state_nxt;
  logic        last;
  logic        rsel;
  logic        rpend;
  logic        gnt0;
  logic        gnt1;
  logic        rd_acc;

  // Pick the port allowed to transfer this cycle; nothing while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        OWN0: gnt0 = 1'b1;
        OWN1: gnt1 = 1'b1;
        default: begin
          if (m0_valid && m1_valid) begin
            if (FIXED_PRIO || last) gnt0 = 1'b1;
            else                    gnt1 = 1'b1;
          end else begin
            gnt0 = m0_valid;
            gnt1 = m1_valid;
          end
        end
      endcase
    end
  end

  assign m0_ready  = gnt0 & m0_valid;
  assign m1_ready  = gnt1 & m1_valid;
  assign mem_valid = m0_ready | m1_ready;
  assign rd_acc    = mem_valid & ~mem_write;

  // Memory port mux; idle cycles show port 0 with no byte enables.
  always_comb begin
    mem_write = m0_write;
    mem_wmask = 4'h0;
    mem_wdata = m0_wdata;
    mem_addr  = m0_addr;
    if (m1_ready) begin
      mem_write = m1_write;
      mem_wmask = m1_wmask;
      mem_wdata = m1_wdata;
      mem_addr  = m1_addr;
    end else if (m0_ready) begin
      mem_wmask = m0_wmask;
    end
  end

  // Lock ownership follows the lock bit of each accepted beat.
  always_comb begin
    state_nxt = state;
    if (m0_ready) begin
      state_nxt = m0_lock ? OWN0 : FREE;
    end else if (m1_ready) begin
      state_nxt = m1_lock ? OWN1 : FREE;
    end else if (state == OWN0 && !m0_valid && !m0_lock) begin
      state_nxt = FREE;
    end else if (state == OWN1 && !m1_valid && !m1_lock) begin
      state_nxt = FREE;
    end
  end

  // Lock state, last winner and read-return bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FREE;
      last  <= 1'b1;
      rpend <= 1'b0;
      rsel  <= 1'b0;
    end else begin
      state <= state_nxt;
      rpend <= rd_acc;
      if (mem_valid) last <= m1_ready;
      if (rd_acc)    rsel <= m1_ready;
    end
  end

  assign m0_rvalid = rpend & ~rsel;
  assign m1_rvalid = rpend & rsel;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: round-robin and fixed-priority instances on shared
// stimulus, each with its own Memory32 model and reference model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_valid, m0_write, m0_lock;
  logic [3:0]  m0_wmask;
  logic [31:0] m0_wdata, m0_addr;
  logic        m1_valid, m1_write, m1_lock;
  logic [3:0]  m1_wmask;
  logic [31:0] m1_wdata, m1_addr;

  logic [1:0]  r0, r1, rv0, rv1, mv, mw;
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic [3:0]  mwm [2];
  logic [31:0] mwd [2];
  logic [31:0] ma  [2];
  logic [31:0] mrd [2];

  logic [31:0] bm   [2][0:8191];
  logic [31:0] rmem [2][0:8191];

  int          own   [2];
  int          lastw [2];
  bit          pend  [2];
  int          pport [2];
  logic [31:0] pdata [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit acc0, acc1;

  mem_port_arbiter #(.FIXED_PRIO(1'b0), .AW(32)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_wmask(m0_wmask),
    .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_lock(m0_lock),
    .m0_ready(r0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_wmask(m1_wmask),
    .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_lock(m1_lock),
    .m1_ready(r1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
    .mem_valid(mv[0]), .mem_write(mw[0]), .mem_wmask(mwm[0]),
    .mem_wdata(mwd[0]), .mem_addr(ma[0]), .mem_rdata(mrd[0])
  );

  mem_port_arbiter #(.FIXED_PRIO(1'b1), .AW(32)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_wmask(m0_wmask),
    .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_lock(m0_lock),
    .m0_ready(r0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_wmask(m1_wmask),
    .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_lock(m1_lock),
    .m1_ready(r1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
    .mem_valid(mv[1]), .mem_write(mw[1]), .mem_wmask(mwm[1]),
    .mem_wdata(mwd[1]), .mem_addr(ma[1]), .mem_rdata(mrd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory32 models: registered read, byte-masked write.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mv[k]) begin
        if (mw[k]) begin
          for (int b = 0; b < 4; b++)
            if (mwm[k][b]) bm[k][ma[k][14:2]][8*b +: 8] <= mwd[k][8*b +: 8];
        end else begin
          mrd[k] <= bm[k][ma[k][14:2]];
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model for instance k: expected outputs now, then advance.
  task automatic model_step(int k);
    string       p;
    int          win;
    logic        wr, lk;
    logic [3:0]  wm;
    logic [31:0] wd, ad;
    p = (k == 0) ? "rr" : "fp";
    if (rst) begin
      chk({p, ".rst_m0_ready"}, 32'(r0[k]), 0);
      chk({p, ".rst_m1_ready"}, 32'(r1[k]), 0);
      chk({p, ".rst_mem_valid"}, 32'(mv[k]), 0);
      chk({p, ".rst_m0_rvalid"}, 32'(rv0[k]), 0);
      chk({p, ".rst_m1_rvalid"}, 32'(rv1[k]), 0);
      own[k]   = -1;
      lastw[k] = 1;
      pend[k]  = 1'b0;
      return;
    end
    win = -1;
    if (own[k] == 0)      win = m0_valid ? 0 : -1;
    else if (own[k] == 1) win = m1_valid ? 1 : -1;
    else if (m0_valid && m1_valid)
      win = (k == 1) ? 0 : ((lastw[k] == 0) ? 1 : 0);
    else if (m0_valid)    win = 0;
    else if (m1_valid)    win = 1;
    if (win == 1) begin
      wr = m1_write; wm = m1_wmask; wd = m1_wdata;
      ad = m1_addr;  lk = m1_lock;
    end else begin
      wr = m0_write; wd = m0_wdata; ad = m0_addr; lk = m0_lock;
      wm = (win == 0) ? m0_wmask : 4'h0;
    end
    chk({p, ".m0_ready"}, 32'(r0[k]), 32'(win == 0));
    chk({p, ".m1_ready"}, 32'(r1[k]), 32'(win == 1));
    chk({p, ".mem_valid"}, 32'(mv[k]), 32'(win >= 0));
    chk({p, ".mem_write"}, 32'(mw[k]), 32'(wr));
    chk({p, ".mem_wmask"}, 32'(mwm[k]), 32'(wm));
    chk({p, ".mem_wdata"}, mwd[k], wd);
    chk({p, ".mem_addr"}, ma[k], ad);
    chk({p, ".m0_rvalid"}, 32'(rv0[k]), 32'(pend[k] && pport[k] == 0));
    chk({p, ".m1_rvalid"}, 32'(rv1[k]), 32'(pend[k] && pport[k] == 1));
    if (pend[k]) begin
      chk({p, ".m0_rdata"}, rd0[k], pdata[k]);
      chk({p, ".m1_rdata"}, rd1[k], pdata[k]);
    end
    pend[k] = (win >= 0) && !wr;
    if (pend[k]) begin
      pport[k] = win;
      pdata[k] = rmem[k][ad[14:2]];
    end
    if (win >= 0 && wr)
      for (int b = 0; b < 4; b++)
        if (wm[b]) rmem[k][ad[14:2]][8*b +: 8] = wd[8*b +: 8];
    if (win >= 0) begin
      lastw[k] = win;
      own[k]   = lk ? win : -1;
    end else if (own[k] == 0 && !m0_valid && !m0_lock) begin
      own[k] = -1;
    end else if (own[k] == 1 && !m1_valid && !m1_lock) begin
      own[k] = -1;
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drv0(logic v, logic w, logic [3:0] m, logic [31:0] d,
                      logic [31:0] a, logic l);
    m0_valid = v; m0_write = w; m0_wmask = m;
    m0_wdata = d; m0_addr = a;  m0_lock = l;
  endtask

  task automatic drv1(logic v, logic w, logic [3:0] m, logic [31:0] d,
                      logic [31:0] a, logic l);
    m1_valid = v; m1_write = w; m1_wmask = m;
    m1_wdata = d; m1_addr = a;  m1_lock = l;
  endtask

  task automatic rnd(output logic v, output logic w, output logic [3:0] m,
                     output logic [31:0] d, output logic [31:0] a,
                     output logic l);
    v = ($urandom_range(0, 2) != 0);
    w = 1'($urandom_range(0, 1));
    m = 4'($urandom);
    d = $urandom;
    a = 32'($urandom_range(0, 63)) << 2;
    l = v ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
  endtask

  logic [3:0]  lk_mask [3];
  logic [31:0] lk_data [3];
  logic        lk_lock [3];

  initial begin
    for (int i = 0; i < 8192; i++) begin
      for (int k = 0; k < 2; k++) begin
        bm[k][i]   = 32'(i) * 32'h9E3779B1;
        rmem[k][i] = 32'(i) * 32'h9E3779B1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      bm[k][16] = 32'hDEADBEEF; rmem[k][16] = 32'hDEADBEEF;
      bm[k][4]  = 32'hC0DE0004; rmem[k][4]  = 32'hC0DE0004;
      bm[k][5]  = 32'hC0DE0005; rmem[k][5]  = 32'hC0DE0005;
      bm[k][8]  = 32'hAABBCCDD; rmem[k][8]  = 32'hAABBCCDD;
      own[k] = -1; lastw[k] = 1; pend[k] = 1'b0; pport[k] = 0;
      pdata[k] = 32'h0;
      mrd[k] = 32'h0;
    end
    lk_mask[0] = 4'hF; lk_data[0] = 32'h11111111; lk_lock[0] = 1'b1;
    lk_mask[1] = 4'h5; lk_data[1] = 32'h22222222; lk_lock[1] = 1'b1;
    lk_mask[2] = 4'hA; lk_data[2] = 32'h33333333; lk_lock[2] = 1'b0;
    rst = 1'b1;
    drv0(0, 0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0);

    samp();
    chk("reset_m0_ready", 32'(r0[0]), 0);
    chk("reset_mem_valid", 32'(mv[0]), 0);

    tick();
    rst = 1'b0;
    drv0(1, 0, 4'h0, 0, 32'h40, 0);
    samp();
    chk("single_read_ready", 32'(r0[0]), 1);
    tick();
    drv0(0, 0, 0, 0, 0, 0);
    samp();
    chk("single_read_rvalid0", 32'(rv0[0]), 1);
    chk("single_read_rdata", rd0[0], 32'hDEADBEEF);
    chk("single_read_rvalid1", 32'(rv1[0]), 0);

    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv0(1, 0, 0, 0, 32'h0, 0);
    drv1(1, 0, 0, 0, 32'h4, 0);
    for (int i = 0; i < 6; i++) begin
      samp();
      chk("rr_grant_m0", 32'(r0[0]), 32'((i % 2) == 0));
      chk("rr_grant_m1", 32'(r1[0]), 32'((i % 2) == 1));
      chk("fp_grant_m0", 32'(r0[1]), 1);
      chk("fp_grant_m1", 32'(r1[1]), 0);
      tick();
    end
    drv1(0, 0, 0, 0, 0, 0);

    drv0(1, 0, 0, 0, 32'h80, 0);
    samp();
    chk("pre_lock_m0", 32'(r0[0]), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv1(1, 1, lk_mask[i], lk_data[i], 32'h100 + 32'(4 * i), lk_lock[i]);
      samp();
      chk("lock_m0_stalled", 32'(r0[0]), 0);
      chk("lock_m1_ready", 32'(r1[0]), 1);
      chk("lock_wmask", 32'(mwm[0]), 32'(lk_mask[i]));
      chk("lock_wdata", mwd[0], lk_data[i]);
      tick();
    end
    drv1(0, 0, 0, 0, 0, 0);
    samp();
    chk("lock_release_m0", 32'(r0[0]), 1);
    tick();
    drv0(0, 0, 0, 0, 0, 0);

    drv0(1, 0, 0, 0, 32'h10, 0);
    samp();
    tick();
    drv0(0, 0, 0, 0, 0, 0);
    drv1(1, 0, 0, 0, 32'h14, 0);
    samp();
    chk("alt_rvalid0", 32'(rv0[0]), 1);
    chk("alt_rdata0", rd0[0], 32'hC0DE0004);
    chk("alt_rvalid1_early", 32'(rv1[0]), 0);
    tick();
    drv1(0, 0, 0, 0, 0, 0);
    samp();
    chk("alt_rvalid1", 32'(rv1[0]), 1);
    chk("alt_rdata1", rd1[0], 32'hC0DE0005);
    chk("alt_rvalid0_late", 32'(rv0[0]), 0);
    tick();

    drv1(1, 1, 4'b0011, 32'h12345678, 32'h20, 0);
    samp();
    chk("wr_m1_ready", 32'(r1[0]), 1);
    tick();
    drv1(0, 0, 0, 0, 0, 0);
    drv0(1, 0, 0, 0, 32'h20, 0);
    samp();
    chk("wr_no_rvalid", 32'(rv0[0] | rv1[0]), 0);
    tick();
    drv0(0, 0, 0, 0, 0, 0);
    samp();
    chk("wr_read_rvalid", 32'(rv0[0]), 1);
    chk("wr_read_rdata", rd0[0], 32'hAABB5678);
    tick();

    drv0(1, 0, 0, 0, 32'h40, 1);
    samp();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_rvalid0", 32'(rv0[0]), 0);
    chk("midrst_m0_ready", 32'(r0[0]), 0);
    chk("midrst_mem_valid", 32'(mv[0]), 0);
    samp();
    tick();
    rst = 1'b0;
    drv0(0, 0, 0, 0, 0, 0);
    drv1(1, 0, 0, 0, 32'h14, 0);
    samp();
    chk("post_rst_m1_ready", 32'(r1[0]), 1);
    tick();
    drv1(0, 0, 0, 0, 0, 0);

    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if (!m0_valid || acc0)
        rnd(m0_valid, m0_write, m0_wmask, m0_wdata, m0_addr, m0_lock);
      if (!m1_valid || acc1)
        rnd(m1_valid, m1_write, m1_wmask, m1_wdata, m1_addr, m1_lock);
      samp();
      acc0 = r0[0];
      acc1 = r1[0];
      tick();
    end
    rst = 1'b0;
    drv0(0, 0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0);
    samp();
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single synchronous Memory32 port (13-bit word address, registered read data, byte-masked writes) between the Pipeline data/instruction master (port 0) and a second master such as a program loader or DMA (port 1). It grants one request per cycle and drives the memory port. It returns read data to the owning requester one cycle later with a valid strobe. It supports a lock for atomic multi-beat sequences. It sits between the masters and Memory32 in the testbench and SoC top.

## Interface
Parameters:
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins when both request and no lock is held.
- AW, 32, address width passed through unchanged.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_valid, m1_valid  in  1  request.
- m0_write, m1_write  in  1  1 = write, 0 = read.
- m0_wmask, m1_wmask  in  4  byte write mask.
- m0_wdata, m1_wdata  in  32  write data.
- m0_addr, m1_addr  in  AW  byte address.
- m0_lock, m1_lock  in  1  keep grant after this transfer.
- m0_ready, m1_ready  out  1  request accepted this cycle (combinational).
- m0_rvalid, m1_rvalid  out  1  read data valid (registered).
- m0_rdata, m1_rdata  out  32  read data, valid when rvalid.
- mem_valid, mem_write  out  1  to memory.
- mem_wmask  out  4; mem_wdata  out  32; mem_addr  out  AW.
- mem_rdata  in  32  memory read data, one cycle after the read was issued.

## Operation
- State: lock FSM {FREE, OWN0, OWN1}; last-grant bit `last`; read-return owner `rsel` and pending flag `rpend`.
- Grant in FREE:
  - Only one port valid: that port is granted.
  - Both ports valid, FIXED_PRIO=1: port 0 is granted.
  - Both ports valid, FIXED_PRIO=0: the port not equal to `last` is granted.
- Grant in OWNn: only port n can be granted. The other port's ready stays 0 even if it is valid.
- mx_ready = granted & mx_valid. mem_valid = OR of the readies. mem_write/wmask/wdata/addr are muxed from the granted port. With no grant they are driven from port 0 with mem_valid=0, and wmask is forced to 0.
- On each accepted transfer, `last` is set to the granted port.
- Lock transitions, evaluated on accepted transfers of port n:
  - lock=1 in FREE or OWNn: next state is OWNn.
  - lock=0: next state is FREE.
  - In OWNn, a cycle with mn_valid=0 and mn_lock=0 also returns the FSM to FREE.
- Read return:
  - An accepted read sets rpend=1 and rsel=port on the next edge. Otherwise rpend is cleared.
  - While rpend=1, the rsel port's rvalid is 1. Both rdata outputs are mem_rdata, unmasked; only rvalid is steered.
- Writes produce no rvalid.
- Back-to-back reads from alternating ports are allowed. Each return cycle is steered by the rsel captured for it.

## Timing
- Reset, asynchronous: FSM=FREE, last=1 (port 0 wins first contention), rpend=0, rsel=0. While rst is high, both ready outputs, mem_valid and both rvalid outputs are 0.
- Request to memory: 0 cycles, combinational.
- Read data: rvalid rises exactly 1 cycle after the accepting edge and lasts 1 cycle per read.
- Throughput: one transfer per cycle. Round-robin with both ports continuously valid alternates grants 0,1,0,1.
- Requester rule: hold valid and all payload stable until ready=1. Lock must be stable with the payload.
- Simultaneous lock requests while FREE: the arbitration winner gets the lock. The loser is stalled until the lock is released.
- Reset mid-read (rpend=1): rvalid drops immediately and the data is discarded.
- Reset while locked: the FSM returns to FREE.

## Test plan
- Single read: m0 read addr 0x40 (memory word 16 = 0xDEADBEEF) → m0_ready=1 in the same cycle. Next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Contention: both ports valid continuously for 6 cycles, FIXED_PRIO=0, after reset → grant order 0,1,0,1,0,1. With FIXED_PRIO=1 → six port-0 grants and m1_ready=0 throughout.
- Lock: m1 issues 3 writes with lock=1,1,0 while m0 is continuously valid → m0_ready=0 for those 3 cycles. m0 is granted on the 4th cycle. mem_wmask and mem_wdata match m1's values each beat.
- Alternating reads: m0 read 0x10, then m1 read 0x14 on consecutive cycles → m0_rvalid on cycle +1 with word 4, m1_rvalid on cycle +2 with word 5, no overlap.
- Write then read: m1 writes 0x12345678 mask 0b0011 to 0x20, then m0 reads 0x20 → low half updated, high half unchanged, and no rvalid follows the write.
- Reset mid-operation: assert rst while rpend=1 and OWN0 → all outputs 0 immediately. After rst drops, m1 alone is granted on its first valid cycle.
